dport_fbfetch: RTL and testbench



---
 rtl/dport_pkg.sv | 25 ++
 rtl/dport_fbfetch_if.sv | 24 ++
 rtl/dport_sfifo.sv | 64 ++++++
 rtl/dport_fbfetch.sv | 202 ++++++++++++++++++++
 tb/tb_dport_fbfetch.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dport_pkg.sv
// Shared geometry of the Blit framebuffer and the fetch FSM state types.
// The pixel converter imports the same constants so both agree on line width.
package dport_pkg;

    localparam int BLITH      = 800;        // active pixels per line, multiple of 32
    localparam int BLITV      = 1024;       // image lines fetched from memory
    localparam int VPAD       = 28;         // zero lines before and after the image
    localparam int FIFO_DEPTH = 16;         // 32-bit response FIFO entries, power of two

    localparam int WPL = BLITH / 32;        // 32-bit memory words per line
    localparam int HPL = BLITH / 16;        // 16-bit output words per line

    typedef enum logic {
        REQ_IDLE,
        REQ_FETCH
    } req_state_e;

    typedef enum logic [1:0] {
        OUT_IDLE,
        OUT_TOPPAD,
        OUT_IMAGE,
        OUT_BOTPAD
    } out_state_e;

endpackage

// File: rtl/dport_fbfetch_if.sv
// Memory read port and raw pixel stream of the framebuffer fetcher.
// master = the fetcher, slave = memory system plus pixel consumer.
interface dport_fbfetch_if;

    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_rd_valid;
    logic [31:0] mem_rd_data;
    logic        raw_pixel_valid;
    logic [15:0] raw_pixel_data;
    logic        raw_pixel_ready;

    modport master (
        output mem_req_valid, mem_req_addr, raw_pixel_valid, raw_pixel_data,
        input  mem_req_ready, mem_rd_valid, mem_rd_data, raw_pixel_ready
    );

    modport slave (
        input  mem_req_valid, mem_req_addr, raw_pixel_valid, raw_pixel_data,
        output mem_req_ready, mem_rd_valid, mem_rd_data, raw_pixel_ready
    );

endinterface

// File: rtl/dport_sfifo.sv
// Synchronous first-word-fall-through FIFO with flush and occupancy count.
// rdata_o always shows the head entry while the FIFO is not empty.
module dport_sfifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      count_q;
    logic             full;
    logic             do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rptr_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full || do_pop);

    // Storage array; contents past the pointers are don't-care, so no reset.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    // Pointers and occupancy; flush empties the FIFO in one cycle.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (do_pop)  rptr_q <= rptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // A push into a full FIFO means the upstream credit accounting is broken.
    always_ff @(posedge clk) begin
        if (!rst && !flush_i) begin
            assert (!(push_i && full && !do_pop));
        end
    end

endmodule

// File: rtl/dport_fbfetch.sv
// Framebuffer fetcher: reads the 1bpp Blit image as 32-bit words and streams
// it out as 16-bit pixel words framed by zero pad lines. Two FSMs: one issues
// credit-limited memory reads, the other sequences TOPPAD/IMAGE/BOTPAD output.
module dport_fbfetch
    import dport_pkg::*;
(
    input  logic            dpclk,
    input  logic            reset,
    input  logic            dpdmavstart,
    input  logic [31:0]     fb_base,
    dport_fbfetch_if.master bus
);

    localparam int CNT_W = 17;
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;
    localparam bit HAS_PAD = (VPAD != 0);
    localparam logic [CNT_W-1:0] REQ_LAST = CNT_W'(BLITV * WPL - 1);
    localparam logic [CNT_W-1:0] PAD_LAST = CNT_W'(VPAD * HPL - 1);
    localparam logic [CNT_W-1:0] IMG_LAST = CNT_W'(BLITV * HPL - 1);

    req_state_e       req_state_q, req_state_d;
    logic [31:0]      addr_q, addr_d;
    logic [CNT_W-1:0] req_cnt_q, req_cnt_d;
    logic [CW-1:0]    outstanding_q, outstanding_d;
    logic [CW-1:0]    discard_q, discard_d;

    out_state_e       out_state_q, out_state_d;
    logic [CNT_W-1:0] hw_cnt_q, hw_cnt_d;
    logic             half_q, half_d;
    logic             valid_q, valid_d;
    logic [15:0]      data_q, data_d;

    logic             fifo_push, fifo_pop, fifo_empty;
    logic [31:0]      fifo_rdata;
    logic [CW-1:0]    fifo_count;
    logic [CW:0]      credit_used;
    logic             req_fire, can_load;

    // Every word in the FIFO or still in flight holds a FIFO slot, so a new
    // request is only issued while that total is below the FIFO depth. The
    // total only grows on an accepted request, so valid never drops while a
    // request waits for ready. A frame restart withdraws any pending request.
    assign credit_used       = {1'b0, fifo_count} + {1'b0, outstanding_q};
    assign bus.mem_req_valid = (req_state_q == REQ_FETCH) && !dpdmavstart
                               && (credit_used < (CW+1)'(FIFO_DEPTH));
    assign bus.mem_req_addr  = addr_q;
    assign req_fire          = bus.mem_req_valid && bus.mem_req_ready;

    // Responses to requests from an aborted frame are dropped while discard
    // is non-zero; in the restart cycle the FIFO is flushed anyway.
    assign fifo_push = bus.mem_rd_valid && (discard_q == '0) && !dpdmavstart;

    assign bus.raw_pixel_valid = valid_q;
    assign bus.raw_pixel_data  = data_q;
    assign can_load            = !valid_q || bus.raw_pixel_ready;

    dport_sfifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (dpclk),
        .rst     (reset),
        .flush_i (dpdmavstart),
        .push_i  (fifo_push),
        .wdata_i (bus.mem_rd_data),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Request FSM next state: address walk, request count, in-flight tracking.
    always_comb begin
        req_state_d   = req_state_q;
        addr_d        = addr_q;
        req_cnt_d     = req_cnt_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;

        case ({req_fire, bus.mem_rd_valid})
            2'b10:   outstanding_d = outstanding_q + CW'(1);
            2'b01:   outstanding_d = outstanding_q - CW'(1);
            default: outstanding_d = outstanding_q;
        endcase

        if (bus.mem_rd_valid && (discard_q != '0)) begin
            discard_d = discard_q - CW'(1);
        end

        if (dpdmavstart) begin
            // Everything still in flight belongs to the old frame.
            req_state_d = REQ_FETCH;
            addr_d      = fb_base;
            req_cnt_d   = '0;
            discard_d   = outstanding_d;
        end else if (req_fire) begin
            addr_d    = addr_q + 32'd4;
            req_cnt_d = req_cnt_q + CNT_W'(1);
            if (req_cnt_q == REQ_LAST) begin
                req_state_d = REQ_IDLE;
                req_cnt_d   = '0;
            end
        end
    end

    // Request FSM registers.
    always_ff @(posedge dpclk) begin
        if (reset) begin
            req_state_q   <= REQ_IDLE;
            addr_q        <= '0;
            req_cnt_q     <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            req_state_q   <= req_state_d;
            addr_q        <= addr_d;
            req_cnt_q     <= req_cnt_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    // Output FSM next state. The counter tracks words loaded into the output
    // register in the current phase; a load happens whenever the register is
    // empty or its word is being accepted, so phases follow back to back. The
    // FIFO entry is popped when its low half moves into the output register.
    always_comb begin
        out_state_d = out_state_q;
        hw_cnt_d    = hw_cnt_q;
        half_d      = half_q;
        valid_d     = valid_q;
        data_d      = data_q;
        fifo_pop    = 1'b0;

        if (dpdmavstart) begin
            out_state_d = HAS_PAD ? OUT_TOPPAD : OUT_IMAGE;
            hw_cnt_d    = '0;
            half_d      = 1'b0;
            valid_d     = 1'b0;
        end else if (can_load) begin
            case (out_state_q)
                OUT_TOPPAD: begin
                    valid_d = 1'b1;
                    data_d  = 16'h0000;
                    if (hw_cnt_q == PAD_LAST) begin
                        hw_cnt_d    = '0;
                        out_state_d = OUT_IMAGE;
                    end else begin
                        hw_cnt_d = hw_cnt_q + CNT_W'(1);
                    end
                end
                OUT_IMAGE: begin
                    if (fifo_empty) begin
                        valid_d = 1'b0;
                    end else begin
                        valid_d  = 1'b1;
                        data_d   = half_q ? fifo_rdata[15:0] : fifo_rdata[31:16];
                        fifo_pop = half_q;
                        half_d   = !half_q;
                        if (hw_cnt_q == IMG_LAST) begin
                            hw_cnt_d    = '0;
                            out_state_d = HAS_PAD ? OUT_BOTPAD : OUT_IDLE;
                        end else begin
                            hw_cnt_d = hw_cnt_q + CNT_W'(1);
                        end
                    end
                end
                OUT_BOTPAD: begin
                    valid_d = 1'b1;
                    data_d  = 16'h0000;
                    if (hw_cnt_q == PAD_LAST) begin
                        hw_cnt_d    = '0;
                        out_state_d = OUT_IDLE;
                    end else begin
                        hw_cnt_d = hw_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    // Output FSM and output register.
    always_ff @(posedge dpclk) begin
        if (reset) begin
            out_state_q <= OUT_IDLE;
            hw_cnt_q    <= '0;
            half_q      <= 1'b0;
            valid_q     <= 1'b0;
            data_q      <= '0;
        end else begin
            out_state_q <= out_state_d;
            hw_cnt_q    <= hw_cnt_d;
            half_q      <= half_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
        end
    end

endmodule

// File: tb/tb_dport_fbfetch.sv
// Directed bench for dport_fbfetch: a memory model with programmable latency
// and request budget, a pixel consumer with optional random backpressure, and
// a reference model of the expected output stream and request addresses.
`timescale 1ns/1ps
module tb_dport_fbfetch;
    import dport_pkg::*;

    localparam int PADW  = VPAD * HPL;
    localparam int IMGW  = BLITV * HPL;
    localparam int TOTAL = 2 * PADW + IMGW;
    localparam int NREQ  = BLITV * WPL;

    typedef struct {
        int          due;
        logic [31:0] data;
    } rsp_t;

    logic        dpclk = 1'b0;
    logic        reset;
    logic        dpdmavstart;
    logic [31:0] fb_base;

    dport_fbfetch_if bus ();

    dport_fbfetch dut (
        .dpclk       (dpclk),
        .reset       (reset),
        .dpdmavstart (dpdmavstart),
        .fb_base     (fb_base),
        .bus         (bus)
    );

    always #5 dpclk = ~dpclk;

    int checks = 0;
    int errors = 0;

    rsp_t        mq[$];
    int          cyc = 0;
    int          lat = 1;
    bit          rand_ready = 1'b0;
    int          req_budget = -1;
    bit          frame_on = 1'b0;
    logic [31:0] base_tb = '0;
    int          k = 0, req_n = 0, out_tb = 0;
    int          data_bad, extra, pad_gap, stable_bad, credit_bad, hold_bad;
    int          addr_bad, withdraw_bad, idle_act;
    bit          stall_prev, req_wait_prev;
    logic [15:0] data_prev, w_a, w_b, w_first;
    logic [31:0] addr_prev, first_addr, last_addr;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        if (a == 32'h1000_0008) return 32'hA5A5_3C3C;
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_5A5A;
    endfunction

    function automatic logic [15:0] exp_word(input int kk);
        logic [31:0] w;
        int          j;
        if (kk < PADW || kk >= PADW + IMGW) return 16'h0000;
        j = kk - PADW;
        w = mem_data(base_tb + 32'(4 * (j / 2)));
        return (j % 2 == 0) ? w[31:16] : w[15:0];
    endfunction

    task automatic clear_stats();
        data_bad = 0; extra = 0; pad_gap = 0; stable_bad = 0; credit_bad = 0;
        hold_bad = 0; addr_bad = 0; withdraw_bad = 0; idle_act = 0;
        stall_prev = 1'b0; req_wait_prev = 1'b0;
        w_a = 'x; w_b = 'x; w_first = 'x; first_addr = 'x; last_addr = 'x;
    endtask

    task automatic observe();
        logic [31:0] a;
        if (!frame_on) begin
            if (bus.raw_pixel_valid) idle_act++;
            if (bus.mem_req_valid)   idle_act++;
        end
        // request side
        if (dpdmavstart && bus.mem_req_valid) withdraw_bad++;
        if (req_wait_prev && !dpdmavstart &&
            (!bus.mem_req_valid || bus.mem_req_addr != addr_prev)) hold_bad++;
        if (bus.mem_req_valid && out_tb >= FIFO_DEPTH) credit_bad++;
        if (bus.mem_req_valid && bus.mem_req_ready) begin
            a = bus.mem_req_addr;
            if (a != base_tb + 32'(4 * req_n)) addr_bad++;
            if (req_n == 0) first_addr = a;
            last_addr = a;
            req_n++;
            if (req_budget > 0) req_budget--;
            mq.push_back('{due: cyc + lat, data: mem_data(a)});
            out_tb++;
        end
        if (bus.mem_rd_valid) out_tb--;
        req_wait_prev = bus.mem_req_valid && !bus.mem_req_ready;
        addr_prev     = bus.mem_req_addr;
        // pixel side
        if (frame_on) begin
            if (stall_prev && (!bus.raw_pixel_valid || bus.raw_pixel_data != data_prev)) stable_bad++;
            if (bus.raw_pixel_valid) begin
                if (k >= TOTAL) extra++;
                else if (bus.raw_pixel_data != exp_word(k)) data_bad++;
                if (k == PADW)     w_first = bus.raw_pixel_data;
                if (k == PADW + 4) w_a = bus.raw_pixel_data;
                if (k == PADW + 5) w_b = bus.raw_pixel_data;
            end else if ((k >= 1 && k < PADW) || (k >= PADW + IMGW && k < TOTAL)) begin
                pad_gap++;
            end
            if (bus.raw_pixel_valid && bus.raw_pixel_ready) k++;
        end
        stall_prev = bus.raw_pixel_valid && !bus.raw_pixel_ready && !dpdmavstart;
        data_prev  = bus.raw_pixel_data;
        if (dpdmavstart) begin
            base_tb  = fb_base;
            k        = 0;
            req_n    = 0;
            frame_on = 1'b1;
        end
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic cycle();
        rsp_t r;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            r = mq.pop_front();
            bus.mem_rd_valid = 1'b1;
            bus.mem_rd_data  = r.data;
        end else begin
            bus.mem_rd_valid = 1'b0;
            bus.mem_rd_data  = '0;
        end
        bus.raw_pixel_ready = rand_ready ? ($urandom_range(0, 9) >= 3) : 1'b1;
        bus.mem_req_ready   = (req_budget != 0);
        #1;
        if (!reset) observe();
        @(posedge dpclk);
        @(negedge dpclk);
        cyc++;
    endtask

    task automatic start_frame(input logic [31:0] base);
        fb_base     = base;
        dpdmavstart = 1'b1;
        cycle();
        dpdmavstart = 1'b0;
    endtask

    task automatic run_until_k(input int target, input int budget, input string tag);
        int n = 0;
        while (k < target && n < budget) begin
            cycle();
            n++;
        end
        check_eq(tag, k >= target, 1);
    endtask

    task automatic wait_out(input int target, input int budget, input string tag);
        int n = 0;
        while (out_tb != target && n < budget) begin
            cycle();
            n++;
        end
        check_eq(tag, out_tb, target);
    endtask

    task automatic check_stream(input string p);
        check_eq({p, "_data_bad"},   data_bad,   0);
        check_eq({p, "_pad_gaps"},   pad_gap,    0);
        check_eq({p, "_stable_bad"}, stable_bad, 0);
        check_eq({p, "_credit_bad"}, credit_bad, 0);
        check_eq({p, "_hold_bad"},   hold_bad,   0);
        check_eq({p, "_addr_bad"},   addr_bad,   0);
        check_eq({p, "_withdraw"},   withdraw_bad, 0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] t;
        int          n;
        reset = 1'b1; dpdmavstart = 1'b0; fb_base = '0;
        bus.mem_req_ready = 1'b0; bus.mem_rd_valid = 1'b0; bus.mem_rd_data = '0;
        bus.raw_pixel_ready = 1'b0;
        clear_stats();
        @(negedge dpclk);
        repeat (3) cycle();
        reset = 1'b0;

        // reset state and idle quiet
        check_eq("rst_pix_valid", bus.raw_pixel_valid, 0);
        check_eq("rst_pix_data",  bus.raw_pixel_data,  0);
        check_eq("rst_req_valid", bus.mem_req_valid,   0);
        repeat (20) cycle();
        check_eq("rst_idle_quiet", idle_act, 0);

        // full frame, ready always high, one-cycle memory
        clear_stats();
        lat = 1; rand_ready = 1'b0; req_budget = -1;
        start_frame(32'h1000_0000);
        run_until_k(TOTAL, 56000, "t1_frame_done");
        repeat (10) cycle();
        check_stream("t1");
        check_eq("t1_words",      k, TOTAL);
        check_eq("t1_extra",      extra, 0);
        check_eq("t1_nreq",       req_n, NREQ);
        check_eq("t1_first_addr", first_addr, 32'h1000_0000);
        check_eq("t1_last_addr",  last_addr, 32'h1000_0000 + 32'(4 * (NREQ - 1)));
        check_eq("t1_hi_half",    w_a, 16'hA5A5);
        check_eq("t1_lo_half",    w_b, 16'h3C3C);
        check_eq("t1_req_idle",   bus.mem_req_valid, 0);
        check_eq("t1_pix_idle",   bus.raw_pixel_valid, 0);

        // 20-cycle memory latency with random consumer backpressure
        clear_stats();
        lat = 20; rand_ready = 1'b1;
        start_frame(32'h1000_0000);
        run_until_k(PADW + 3000, 9000, "t2_progress");
        check_stream("t2");
        check_eq("t2_hi_half", w_a, 16'hA5A5);
        check_eq("t2_lo_half", w_b, 16'h3C3C);

        // restart mid-image with exactly five requests in flight
        req_budget = 0;
        wait_out(0, 200, "t4_drain");
        req_budget = 5;
        wait_out(5, 100, "t4_five_out");
        clear_stats();
        req_budget = -1;
        start_frame(32'h2000_0000);
        check_eq("t4_discard", dut.discard_q, 5);
        run_until_k(PADW + 1000, 6000, "t4_progress");
        check_stream("t4");
        t = mem_data(32'h2000_0000);
        check_eq("t4_first_img",  w_first, t[31:16]);
        check_eq("t4_first_addr", first_addr, 32'h2000_0000);
        check_eq("t4_discard_end", dut.discard_q, 0);

        // restart in the same cycle as a response with three in flight
        rand_ready = 1'b0;
        req_budget = 0;
        wait_out(0, 200, "t5_drain");
        req_budget = 3;
        wait_out(3, 100, "t5_three_out");
        n = 0;
        while (!(mq.size() > 0 && mq[0].due <= cyc) && n < 40) begin
            cycle();
            n++;
        end
        check_eq("t5_rsp_due", (mq.size() > 0 && mq[0].due <= cyc), 1);
        clear_stats();
        req_budget = -1;
        start_frame(32'h3000_0000);
        check_eq("t5_discard", dut.discard_q, 2);
        run_until_k(PADW + 600, 3000, "t5_progress");
        check_stream("t5");
        t = mem_data(32'h3000_0000);
        check_eq("t5_first_img", w_first, t[31:16]);

        // reset mid-frame together with a frame start
        mq.delete();
        reset = 1'b1;
        dpdmavstart = 1'b1;
        cycle();
        dpdmavstart = 1'b0;
        cycle();
        reset = 1'b0;
        frame_on = 1'b0; k = 0; req_n = 0; out_tb = 0;
        clear_stats();
        check_eq("t6_pix_valid", bus.raw_pixel_valid, 0);
        check_eq("t6_pix_data",  bus.raw_pixel_data,  0);
        check_eq("t6_req_valid", bus.mem_req_valid,   0);
        check_eq("t6_out_idle",  dut.out_state_q, OUT_IDLE);
        check_eq("t6_req_idle",  dut.req_state_q, REQ_IDLE);
        repeat (50) cycle();
        check_eq("t6_idle_quiet", idle_act, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
